// File: rtl/inst_queue_pkg.sv
// Shared widths, entry layout and helpers for the instruction queue.
// An entry is stored as one flat vector: {inst, pc, pred_jump, pred_pc}.
package inst_queue_pkg;

  localparam int INST_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int IQ_ENTRY_W = INST_W + 2 * ADDR_W + 1;

  // Field offsets inside a flat entry (LSB positions).
  localparam int PRED_PC_LSB   = 0;
  localparam int PRED_JUMP_BIT = ADDR_W;
  localparam int PC_LSB        = ADDR_W + 1;
  localparam int INST_LSB      = 2 * ADDR_W + 1;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Build a flat entry from its fields.
  function automatic logic [IQ_ENTRY_W-1:0] pack_entry(
    input logic [INST_W-1:0] inst,
    input logic [ADDR_W-1:0] pc,
    input logic              pred_jump,
    input logic [ADDR_W-1:0] pred_pc
  );
    return {inst, pc, pred_jump, pred_pc};
  endfunction

endpackage

// File: rtl/inst_queue_entry_ram.sv
// Entry storage for the instruction queue: synchronous write port at the
// tail, combinational read port at the head. The array is deliberately
// not reset; validity is tracked entirely by the pointers and count.
module iq_entry_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 97,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the pushed entry at the tail slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The head entry is visible in the same cycle so the output slot can load it.
  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
//
// Input side: the fetcher pushes with if_valid; there is no per-push
// acknowledge. is_full rises one entry early (count >= DEPTH-1) because the
// fetcher reacts to it a cycle late, so one push may already be in flight.
//
// Output side (valid/ready): out_valid says out_* hold an entry; the entry is
// consumed at a rising edge where out_valid=1 and dec_ready=1. The slot
// reloads from storage whenever it is empty or being consumed, so a held
// entry (dec_ready=0) stays stable. There is no bypass from if_* to out_*.
//
// rdy=0 freezes everything; rob_roll_back flushes everything and wins over
// any same-cycle push or consume.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_valid,
  input  logic [INST_W-1:0] if_inst,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_pred_jump,
  input  logic [ADDR_W-1:0] if_pred_pc,
  output logic              is_full,
  input  logic              dec_ready,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_pred_jump,
  output logic [ADDR_W-1:0] out_pred_pc,
  input  logic              rob_roll_back
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic [IQ_ENTRY_W-1:0] wr_entry;
  logic [IQ_ENTRY_W-1:0] rd_entry;
  logic                  push;
  logic                  load;
  logic                  pop;
  logic                  ram_we;

  // Decide this cycle's push/load/pop from the current occupancy.
  // A push into a completely full store is a fetcher error and is dropped.
  always_comb begin
    wr_entry = pack_entry(if_inst, if_pc, if_pred_jump, if_pred_pc);
    push     = if_valid && (count != CNT_W'(DEPTH));
    load     = !out_valid || dec_ready;
    pop      = load && (count != '0);
    ram_we   = rdy && !rob_roll_back && push;
  end

  // One slot is held back to absorb the push already in flight.
  assign is_full = (count >= CNT_W'(DEPTH - 1));

  iq_entry_ram #(
    .DEPTH (DEPTH),
    .WIDTH (IQ_ENTRY_W),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (rd_entry)
  );

  // Pointers, count and the registered output slot; flush has top priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      out_valid     <= 1'b0;
      out_inst      <= '0;
      out_pc        <= '0;
      out_pred_jump <= 1'b0;
      out_pred_pc   <= '0;
    end else if (rdy) begin
      if (rob_roll_back) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        out_valid <= 1'b0;
      end else begin
        if (push) begin
          tail <= tail + PTR_W'(1);
        end
        if (pop) begin
          head          <= head + PTR_W'(1);
          out_valid     <= 1'b1;
          out_inst      <= rd_entry[INST_LSB +: INST_W];
          out_pc        <= rd_entry[PC_LSB +: ADDR_W];
          out_pred_jump <= rd_entry[PRED_JUMP_BIT];
          out_pred_pc   <= rd_entry[PRED_PC_LSB +: ADDR_W];
        end else if (load) begin
          // Nothing to hand over: slot empties, data fields keep old values.
          out_valid <= 1'b0;
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios followed by a randomized phase.
// A queue-based reference model predicts storage and output-slot contents;
// every entry it hands to the output slot is pushed onto exp_q, and a
// monitor pops and compares whenever the DUT loads its output slot.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int EW    = IQ_ENTRY_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              if_valid;
  logic [INST_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic              if_pred_jump;
  logic [ADDR_W-1:0] if_pred_pc;
  logic              is_full;
  logic              dec_ready;
  logic              out_valid;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              out_pred_jump;
  logic [ADDR_W-1:0] out_pred_pc;
  logic              rob_roll_back;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .if_valid      (if_valid),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .if_pred_jump  (if_pred_jump),
    .if_pred_pc    (if_pred_pc),
    .is_full       (is_full),
    .dec_ready     (dec_ready),
    .out_valid     (out_valid),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_pred_jump (out_pred_jump),
    .out_pred_pc   (out_pred_pc),
    .rob_roll_back (rob_roll_back)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [EW-1:0] st_q[$];   // entries held in storage, oldest first
  logic [EW-1:0] exp_q[$];  // entries expected to appear in the output slot
  logic [EW-1:0] m_out;
  logic          m_out_valid = 1'b0;
  int            m_pushes = 0;  // pushes since last clear (tail position)
  int            m_pops   = 0;  // pops since last clear (head position)

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_clear();
    st_q.delete();
    exp_q.delete();
    m_out_valid = 1'b0;
    m_pushes    = 0;
    m_pops      = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_update();
    int sz;
    if (!rst || !rdy) return;
    if (rob_roll_back) begin
      model_clear();
      return;
    end
    sz = st_q.size();
    if (!m_out_valid || dec_ready) begin
      if (sz > 0) begin
        m_out       = st_q.pop_front();
        m_out_valid = 1'b1;
        m_pops++;
        exp_q.push_back(m_out);
      end else begin
        m_out_valid = 1'b0;
      end
    end
    if (if_valid && sz < DEPTH) begin
      st_q.push_back({if_inst, if_pc, if_pred_jump, if_pred_pc});
      m_pushes++;
    end
  endtask

  // One clock: model steps after the monitor's sample, then the edge occurs.
  task automatic tick();
    @(negedge clk);
    #1;
    model_update();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic armed = 1'b0;
  always @(negedge clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    if (rst) begin
      if (armed && out_valid) begin
        act = {out_inst, out_pc, out_pred_jump, out_pred_pc};
        if (exp_q.size() == 0) begin
          check("unexpected_load", act, '0);
        end else begin
          exp = exp_q.pop_front();
          check("out_entry", act, exp);
        end
      end
      check("out_valid", out_valid, m_out_valid);
      check("count", dut.count, st_q.size());
      check("is_full", is_full, st_q.size() >= DEPTH - 1);
      check("head", dut.head, m_pops % DEPTH);
      check("tail", dut.tail, m_pushes % DEPTH);
    end
    armed = rst && rdy && !rob_roll_back && (!out_valid || dec_ready);
  end

  // ---------------- driver helpers ----------------
  logic [ADDR_W-1:0] next_pc;

  task automatic set_push(input logic v, input logic [ADDR_W-1:0] pc);
    if_valid     = v;
    if_inst      = $urandom;
    if_pc        = pc;
    if_pred_jump = 1'($urandom_range(0, 1));
    if_pred_pc   = $urandom;
  endtask

  task automatic drain(input int n);
    if_valid      = 1'b0;
    dec_ready     = 1'b1;
    rob_roll_back = 1'b0;
    rdy           = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic prev_full;
    logic cur_full;
    logic seen_rise;
    int   guard;

    rst = 1'b0; rdy = 1'b1; dec_ready = 1'b0; rob_roll_back = 1'b0;
    set_push(1'b0, '0);
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_inst", out_inst, '0);
    check("rst_out_pc", out_pc, '0);
    check("rst_out_pred_jump", out_pred_jump, 1'b0);
    check("rst_out_pred_pc", out_pred_pc, '0);
    check("rst_is_full", is_full, 1'b0);
    rst = 1'b1;

    // Reset mid-operation: six pushes with decode stalled -> slot + 5 stored.
    for (int i = 0; i < 6; i++) begin
      set_push(1'b1, 32'h1000 + 32'(i * 4));
      tick();
    end
    set_push(1'b0, '0);
    check("pre_rst_count", dut.count, 5);
    check("pre_rst_out_valid", out_valid, 1'b1);
    rst = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_is_full", is_full, 1'b0);
    model_clear();
    tick();
    rst = 1'b1;
    set_push(1'b1, 32'h0);
    tick();
    set_push(1'b0, '0);
    tick();
    check("post_rst_out_pc", out_pc, 32'h0);
    check("post_rst_out_valid", out_valid, 1'b1);
    drain(4);

    // Order and fields.
    dec_ready = 1'b0;
    if_valid = 1'b1;
    if_inst = 32'h13; if_pc = 32'h0;  if_pred_jump = 1'b0; if_pred_pc = 32'h4;  tick();
    if_inst = 32'h6f; if_pc = 32'h4;  if_pred_jump = 1'b1; if_pred_pc = 32'h20; tick();
    if_inst = 32'h93; if_pc = 32'h20; if_pred_jump = 1'b0; if_pred_pc = 32'h24; tick();
    if_valid = 1'b0;
    check("ord0", {out_inst, out_pc, out_pred_jump, out_pred_pc}, {32'h13, 32'h0, 1'b0, 32'h4});
    dec_ready = 1'b1;
    tick();
    check("ord1", {out_inst, out_pc, out_pred_jump, out_pred_pc}, {32'h6f, 32'h4, 1'b1, 32'h20});
    tick();
    check("ord2", {out_inst, out_pc, out_pred_jump, out_pred_pc}, {32'h93, 32'h20, 1'b0, 32'h24});
    drain(3);
    check("ord_drained_valid", out_valid, 1'b0);

    // Fill with decode stalled; the fetcher sees is_full one cycle late.
    dec_ready = 1'b0;
    next_pc   = '0;
    prev_full = 1'b0;
    cur_full  = 1'b0;
    seen_rise = 1'b0;
    for (int i = 0; i < 24; i++) begin
      set_push(!prev_full, next_pc);
      if (!prev_full) next_pc = next_pc + 32'h4;
      tick();
      prev_full = cur_full;
      cur_full  = is_full;
      if (cur_full && !seen_rise) begin
        seen_rise = 1'b1;
        check("full_rise_count", dut.count, 15);
      end
    end
    set_push(1'b0, '0);
    check("fill_count", dut.count, 16);
    check("fill_out_pc_held", out_pc, 32'h0);
    check("fill_is_full", is_full, 1'b1);
    check("fill_accepted_pcs", next_pc, 32'h44);

    // Concurrent push and pop at count 15.
    dec_ready = 1'b1;
    tick();
    check("pop_out_pc", out_pc, 32'h4);
    check("pop_count", dut.count, 15);
    set_push(1'b1, next_pc);
    tick();
    set_push(1'b0, '0);
    check("pushpop_count", dut.count, 15);
    check("pushpop_is_full", is_full, 1'b1);
    check("pushpop_out_pc", out_pc, 32'h8);

    // Roll back with a same-cycle push.
    guard = 0;
    while (st_q.size() > 8 && guard < 20) begin
      tick();
      guard++;
    end
    check("rb_pre_count", dut.count, 8);
    check("rb_pre_valid", out_valid, 1'b1);
    rob_roll_back = 1'b1;
    set_push(1'b1, 32'h40);
    tick();
    rob_roll_back = 1'b0;
    set_push(1'b0, '0);
    check("rb_out_valid", out_valid, 1'b0);
    check("rb_count", dut.count, 0);
    set_push(1'b1, 32'h100);
    tick();
    set_push(1'b0, '0);
    tick();
    check("rb_new_out_pc", out_pc, 32'h100);
    check("rb_new_out_valid", out_valid, 1'b1);

    // rdy stall: build a little state, then freeze for three cycles.
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 32'h200 + 32'(i * 4));
      tick();
    end
    rdy = 1'b0;
    dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 32'h300 + 32'(i * 4));
      tick();
      check("stall_count", dut.count, 4);
      check("stall_out_pc", out_pc, 32'h100);
      check("stall_out_valid", out_valid, 1'b1);
    end
    rdy = 1'b1;
    set_push(1'b0, '0);
    tick();
    check("resume_out_pc", out_pc, 32'h200);
    check("resume_count", dut.count, 3);
    drain(8);

    // Randomized traffic, including pushes into a full store.
    next_pc = 32'h8000;
    for (int i = 0; i < 400; i++) begin
      rdy           = ($urandom_range(0, 9) != 0);
      rob_roll_back = ($urandom_range(0, 39) == 0);
      dec_ready     = ($urandom_range(0, 9) < 5);
      set_push($urandom_range(0, 9) < 7, next_pc);
      next_pc = next_pc + 32'h4;
      tick();
    end
    drain(24);
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_out_valid", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
